lsu_bus: RTL

- Second-generation load-store unit between the core's memory stage and the data memory, output peripherals and input peripherals.
- Replaces the single-cycle combinational access with a request/acknowledge transaction:
  - byte-masked writes to a wait-stated external data memory;
  - load lane extraction from the addressed byte offset;
  - misalignment and timeout reporting;
  - parametrised output and input window sizes.
- One transaction in flight at a time. The core stalls until o_ack.

---
 rtl/lsu_bus.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_bus.sv
// lsu_bus: load-store unit between the core memory stage and the data memory,
// the output register window and the input register window.
//
// A transaction is a request/acknowledge exchange. Only one is in flight at a
// time, and the core stalls until o_ack.
//   - Data window accesses are forwarded to a wait-stated memory. The memory
//     port uses a request held until i_mem_ack, and the access is aborted
//     after TMO_CYC cycles.
//   - Peripheral, unmapped and erroneous accesses complete on the request edge.
//
// Ports:
//   i_clk, i_rst      clock (rising edge), synchronous active-high reset
//   i_req/i_wren      request strobe (sampled in IDLE) and store select
//   i_func3           RV32 funct3 (B/H/W, bit 2 = unsigned load)
//   i_lsu_addr        byte address
//   i_st_data         right-aligned store data
//   o_ack             one-cycle completion pulse, with:
//                       o_ld_data, o_misalign, o_timeout
//   o_mem_*           data memory request port (word address, byte enables)
//   i_mem_rdata/ack   data memory response
//   i_io_sw/i_io_btn  input pins, captured every cycle
//   o_io_*            output register window contents
//
// Build option:
//   LSU_IO_SYNC_EN    when defined, sw/btn pass through a two-flop
//                     synchronizer (a pin change is visible two cycles later
//                     instead of one).
`timescale 1ns/1ps
module lsu_bus #(
  parameter int DMEM_AW   = 13,
  parameter int OUT_BYTES = 64,
  parameter int IN_BYTES  = 32,
  parameter int TMO_CYC   = 255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req,
  input  logic               i_wren,
  input  logic [2:0]         i_func3,
  input  logic [31:0]        i_lsu_addr,
  input  logic [31:0]        i_st_data,
  output logic               o_ack,
  output logic [31:0]        o_ld_data,
  output logic               o_misalign,
  output logic               o_timeout,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic [DMEM_AW-3:0] o_mem_addr,
  output logic [31:0]        o_mem_wdata,
  output logic [3:0]         o_mem_bmask,
  input  logic [31:0]        i_mem_rdata,
  input  logic               i_mem_ack,
  input  logic [31:0]        i_io_sw,
  input  logic [31:0]        i_io_btn,
  output logic [31:0]        o_io_ledr,
  output logic [31:0]        o_io_ledg,
  output logic [55:0]        o_io_hex,
  output logic [31:0]        o_io_lcd
);

  localparam int OUT_AW = $clog2(OUT_BYTES);
  localparam int IN_AW  = $clog2(IN_BYTES);
  localparam int OUT_IW = OUT_AW - 2;
  localparam int IN_IW  = IN_AW - 2;
  localparam int TMO_W  = $clog2(TMO_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [TMO_W-1:0]    tmo_cnt_q;
  logic                mem_we_q;
  logic [DMEM_AW-3:0]  mem_addr_q;
  logic [31:0]         mem_wdata_q;
  logic [3:0]          mem_bmask_q;
  logic [1:0]          ld_off_q;
  logic [2:0]          ld_f3_q;
  logic [31:0]         ld_q;
  logic                mis_q;
  logic                tmo_q;
  logic [31:0]         ledr_q, ledg_q, lcd_q;
  logic [63:0]         hex_q;
  logic [31:0]         sw_cap_q;
  logic [7:0]          btn_cap_q;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ld_extract(input logic [31:0] w,
                                             input logic [1:0]  off,
                                             input logic [2:0]  f3);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    case (f3[1:0])
      2'b00:   return f3[2] ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return f3[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  // Request decode
  logic [1:0]        off;
  logic              f3_legal, misal, err;
  logic              is_dmem, is_out, is_in;
  logic [3:0]        bmask;
  logic [31:0]       wdata;
  logic [OUT_IW-1:0] out_idx;
  logic [IN_IW-1:0]  in_idx;
  logic [31:0]       periph_rd;
  logic              tmo_hit;

  assign off     = i_lsu_addr[1:0];
  assign is_dmem = (i_lsu_addr[15:13] == 3'b001);
  assign is_out  = (i_lsu_addr[15:12] == 4'h7) && !i_lsu_addr[11];
  assign is_in   = (i_lsu_addr[15:11] == 5'b01111);
  assign out_idx = i_lsu_addr[OUT_AW-1:2];
  assign in_idx  = i_lsu_addr[IN_AW-1:2];
  assign wdata   = i_st_data << {off, 3'b000};
  assign tmo_hit = (tmo_cnt_q == TMO_W'(TMO_CYC - 1));

  always_comb begin
    f3_legal = 1'b0;
    case (i_func3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !i_wren;
      default:                f3_legal = 1'b0;
    endcase
    misal = ((i_func3[1:0] == 2'b01) && off[0]) ||
            ((i_func3[1:0] == 2'b10) && (off != 2'b00));
    err   = !f3_legal || misal;
    case (i_func3[1:0])
      2'b00:   bmask = 4'b0001 << off;
      2'b01:   bmask = 4'b0011 << off;
      default: bmask = 4'b1111;
    endcase
  end

  // Peripheral read word; unimplemented offsets and unmapped space read 0.
  always_comb begin
    periph_rd = '0;
    if (is_out) begin
      if (out_idx == OUT_IW'(0))       periph_rd = ledr_q;
      else if (out_idx == OUT_IW'(4))  periph_rd = ledg_q;
      else if (out_idx == OUT_IW'(8))  periph_rd = hex_q[31:0];
      else if (out_idx == OUT_IW'(9))  periph_rd = hex_q[63:32];
      else if (out_idx == OUT_IW'(12)) periph_rd = lcd_q;
    end else if (is_in) begin
      if (in_idx == IN_IW'(0))         periph_rd = sw_cap_q;
      else if (in_idx == IN_IW'(4))    periph_rd = {24'b0, btn_cap_q};
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_req) state_d = (!err && is_dmem) ? S_MEM : S_RESP;
      S_MEM:  if (i_mem_ack || tmo_hit) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Transaction registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      tmo_cnt_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_bmask_q <= '0;
      ld_off_q    <= '0;
      ld_f3_q     <= '0;
      ld_q        <= '0;
      mis_q       <= 1'b0;
      tmo_q       <= 1'b0;
      ledr_q      <= '0;
      ledg_q      <= '0;
      hex_q       <= '0;
      lcd_q       <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (i_req) begin
          tmo_cnt_q <= '0;
          mis_q     <= err;
          tmo_q     <= 1'b0;
          ld_q      <= '0;
          if (!err) begin
            if (is_dmem) begin
              mem_we_q    <= i_wren;
              mem_addr_q  <= i_lsu_addr[DMEM_AW-1:2];
              mem_wdata_q <= wdata;
              mem_bmask_q <= bmask;
              ld_off_q    <= off;
              ld_f3_q     <= i_func3;
            end else if (i_wren) begin
              if (is_out) begin
                if (out_idx == OUT_IW'(0))       ledr_q <= merge_bytes(ledr_q, wdata, bmask);
                else if (out_idx == OUT_IW'(4))  ledg_q <= merge_bytes(ledg_q, wdata, bmask);
                else if (out_idx == OUT_IW'(8))  hex_q[31:0]  <= merge_bytes(hex_q[31:0], wdata, bmask);
                else if (out_idx == OUT_IW'(9))  hex_q[63:32] <= merge_bytes(hex_q[63:32], wdata, bmask);
                else if (out_idx == OUT_IW'(12)) lcd_q  <= merge_bytes(lcd_q, wdata, bmask);
              end
            end else begin
              ld_q <= ld_extract(periph_rd, off, i_func3);
            end
          end
        end
        S_MEM: begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
          if (i_mem_ack) begin
            ld_q <= mem_we_q ? 32'b0 : ld_extract(i_mem_rdata, ld_off_q, ld_f3_q);
          end else if (tmo_hit) begin
            tmo_q <= 1'b1;
            ld_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Input capture
`ifdef LSU_IO_SYNC_EN
  logic [31:0] sw_meta_q;
  logic [7:0]  btn_meta_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sw_meta_q  <= '0;
      btn_meta_q <= '0;
      sw_cap_q   <= '0;
      btn_cap_q  <= '0;
    end else begin
      sw_meta_q  <= i_io_sw;
      btn_meta_q <= i_io_btn[7:0];
      sw_cap_q   <= sw_meta_q;
      btn_cap_q  <= btn_meta_q;
    end
  end
`else
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sw_cap_q  <= '0;
      btn_cap_q <= '0;
    end else begin
      sw_cap_q  <= i_io_sw;
      btn_cap_q <= i_io_btn[7:0];
    end
  end
`endif

  // Outputs
  assign o_ack       = (state_q == S_RESP);
  assign o_ld_data   = o_ack ? ld_q : 32'b0;
  assign o_misalign  = o_ack && mis_q;
  assign o_timeout   = o_ack && tmo_q;
  assign o_mem_req   = (state_q == S_MEM);
  assign o_mem_we    = o_mem_req && mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_bmask = mem_bmask_q;
  assign o_io_ledr   = ledr_q;
  assign o_io_ledg   = ledg_q;
  assign o_io_lcd    = lcd_q;

  // Each digit keeps the low 7 bits of its byte.
  always_comb begin
    o_io_hex = '0;
    for (int n = 0; n < 8; n++) o_io_hex[7*n +: 7] = hex_q[8*n +: 7];
  end

  logic unused_ok;
  assign unused_ok = ^{i_lsu_addr[31:16], i_io_btn[31:8]};

endmodule
